// File: rtl/jk_pkg.sv
// Shared types and excitation encoding for the JK bank driver.
// Excitation codes are {J,K}; the JK toggle code is never generated.
package jk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck
  } jk_state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_RST  = 2'b01;

  // Map current bit c and target bit t to {J,K}; don't-cares resolve to 0.
  function automatic logic [1:0] jk_excite(input logic c, input logic t);
    logic [1:0] code;
    unique case ({c, t})
      2'b01:   code = JK_SET;
      2'b10:   code = JK_RST;
      default: code = JK_HOLD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/jk_excite_drv_if.sv
// Target-word valid/ready handshake between a pattern source and the JK driver.
interface jk_excite_drv_if #(
  parameter int unsigned W = 4
);
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         tgt_ready;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excite_bit.sv
// Combinational per-bit mapper from (current, target) to JK excitation.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic c,
  input  logic t,
  output logic j,
  output logic k
);

  assign {j, k} = jk_excite(c, t);

endmodule

// File: rtl/jk_excite_drv.sv
// Drives J/K and a one-cycle load enable into a JK register bank, then checks
// the bank's feedback against the requested target and counts mismatches.
module jk_excite_drv
  import jk_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_excite_drv_if.slave   tgt,
  output logic [W-1:0]     j,
  output logic [W-1:0]     k,
  output logic             jk_en,
  input  logic [W-1:0]     q_fb,
  output logic [W-1:0]     cur_state,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  jk_state_e      state_q, state_d;
  logic [W-1:0]   tgt_q;
  logic [W-1:0]   j_q, k_q;
  logic [W-1:0]   j_ex, k_ex;
  logic [W-1:0]   cur_state_q;
  logic [ERR_W-1:0] err_q;
  logic           accept;

  // Excitation is derived from the tracked state, not the live feedback.
  for (genvar i = 0; i < W; i++) begin : g_bit
    jk_excite_bit u_bit (
      .c (cur_state_q[i]),
      .t (tgt.tgt_data[i]),
      .j (j_ex[i]),
      .k (k_ex[i])
    );
  end

  assign accept = tgt.tgt_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDrive;
      StDrive:  state_d = StSettle;
      StSettle: state_d = StCheck;
      StCheck:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tgt.tgt_ready = (state_q == StIdle);
    busy          = (state_q != StIdle);
    jk_en         = (state_q == StDrive);
    j             = jk_en ? j_q : '0;
    k             = jk_en ? k_q : '0;
    mismatch      = (state_q == StCheck) && (q_fb != tgt_q);
    cur_state     = cur_state_q;
    err_cnt       = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tgt_q       <= '0;
      j_q         <= '0;
      k_q         <= '0;
      cur_state_q <= '0;
      err_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tgt_q <= tgt.tgt_data;
        j_q   <= j_ex;
        k_q   <= k_ex;
      end
      // Resync to the real bank state even on a mismatch.
      if (state_q == StCheck) begin
        cur_state_q <= q_fb;
        if (mismatch && (err_q != {ERR_W{1'b1}})) begin
          err_q <= err_q + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_excite_drv.sv
// Scoreboard bench: a JK bank model closes the loop, a reference model predicts
// excitation and check outcomes, and a negedge monitor compares.
module tb_jk_excite_drv;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jk_excite_drv_if #(.W(W)) tif ();
  jk_excite_drv_if #(.W(W)) tif2 ();

  logic [W-1:0] j, k, cur_state, q_fb, bank, bank_nx, fault_mask;
  logic         jk_en, mismatch, busy;
  logic [7:0]   err_cnt;

  logic [W-1:0] j2, k2, cur2;
  logic         jk_en2, mis2, busy2;
  logic [1:0]   err2;

  jk_excite_drv #(.W(W), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt       (tif.slave),
    .j         (j),
    .k         (k),
    .jk_en     (jk_en),
    .q_fb      (q_fb),
    .cur_state (cur_state),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  // Second instance: narrow counter, feedback stuck at zero.
  assign tif2.tgt_valid = tif.tgt_valid;
  assign tif2.tgt_data  = tif.tgt_data;

  jk_excite_drv #(.W(W), .ERR_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt       (tif2.slave),
    .j         (j2),
    .k         (k2),
    .jk_en     (jk_en2),
    .q_fb      ('0),
    .cur_state (cur2),
    .mismatch  (mis2),
    .err_cnt   (err2),
    .busy      (busy2)
  );

  // Behavioural JK bank; a faulted bit is held at 0 internally as well.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (jk_en) begin
      bank_nx = bank;
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b10:   bank_nx[i] = 1'b1;
          2'b01:   bank_nx[i] = 1'b0;
          2'b11:   bank_nx[i] = ~bank[i];
          default: ;
        endcase
      end
      bank <= bank_nx & ~fault_mask;
    end
  end
  assign q_fb = bank & ~fault_mask;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] t;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] fb;
    logic         mis;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  exp_t         nw;
  int           stage = 0;
  logic [W-1:0] model_cur = '0;
  int           model_err = 0;
  int           model_err2 = 0;
  int           model_mis2 = 0;
  int           seen_mis2 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stage     = 0;
      model_cur = '0;
      model_err = 0;
      model_err2 = 0;
    end else begin
      if (mis2) seen_mis2++;
      check("j_and_k", 32'(j & k), 32'd0);
      case (stage)
        1: begin
          check("sb_depth", 32'(sb.size()), 32'd1);
          if (sb.size() > 0) cur = sb.pop_front();
          check("drive_jk_en", 32'(jk_en), 32'd1);
          check("drive_j", 32'(j), 32'(cur.j));
          check("drive_k", 32'(k), 32'(cur.k));
          stage = 2;
        end
        2: begin
          check("settle_jk_en", 32'(jk_en), 32'd0);
          check("settle_jk", 32'({j, k}), 32'd0);
          check("settle_ready", 32'(tif.tgt_ready), 32'd0);
          stage = 3;
        end
        3: begin
          check("check_mismatch", 32'(mismatch), 32'(cur.mis));
          check("check_mismatch2", 32'(mis2), 32'(cur.t != '0));
          model_cur = cur.fb;
          if (cur.mis && model_err < 255) model_err++;
          if (cur.t != '0) begin
            model_mis2++;
            if (model_err2 < 3) model_err2++;
          end
          stage = 4;
        end
        4: begin
          check("cur_state", 32'(cur_state), 32'(model_cur));
          check("err_cnt", 32'(err_cnt), 32'(model_err));
          check("err_cnt_w2", 32'(err2), 32'(model_err2));
          stage = 0;
        end
        default: ;
      endcase
      if (stage == 0) begin
        check("idle_ready", 32'(tif.tgt_ready), 32'd1);
        check("idle_jk_en", 32'(jk_en), 32'd0);
        check("idle_mismatch", 32'(mismatch), 32'd0);
        if (tif.tgt_valid && tif.tgt_ready) begin
          nw.t   = tif.tgt_data;
          nw.j   = tif.tgt_data & ~model_cur;
          nw.k   = model_cur & ~tif.tgt_data;
          nw.fb  = tif.tgt_data & ~fault_mask;
          nw.mis = (nw.fb != tif.tgt_data);
          sb.push_back(nw);
          stage = 1;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] t);
    int n = 0;
    @(posedge clk);
    #1;
    tif.tgt_valid = 1'b1;
    tif.tgt_data  = t;
    @(negedge clk);
    while (!tif.tgt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    tif.tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((stage != 0 || busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_j"}, 32'(j), 32'd0);
    check({tag, "_k"}, 32'(k), 32'd0);
    check({tag, "_jk_en"}, 32'(jk_en), 32'd0);
    check({tag, "_cur_state"}, 32'(cur_state), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_ready"}, 32'(tif.tgt_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_cnt_w2"}, 32'(err2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    fault_mask    = '0;
    tif.tgt_valid = 1'b0;
    tif.tgt_data  = '0;
    #2 rst_n = 1'b0;
    #10 check_reset("por");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Basic targets, then a target equal to the current state.
    send(4'b1010);
    send(4'b0101);
    send(4'b0101);
    wait_idle();

    // Reset asserted during SETTLE discards the in-flight word.
    send(4'b0011);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("mid_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(4'b0110);
    wait_idle();

    // Stuck-at-0 on bit 0, introduced while that bit is already 0.
    send(4'b0000);
    wait_idle();
    fault_mask = 4'b0001;
    send(4'b0001);
    send(4'b0001);
    wait_idle();
    send(4'b0000);
    wait_idle();
    fault_mask = '0;

    // Random valid with data changing every cycle, including while busy.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      tif.tgt_valid = ($urandom_range(3) != 0);
      tif.tgt_data  = W'($urandom);
    end
    @(posedge clk);
    #1 tif.tgt_valid = 1'b0;
    wait_idle();
    wait_idle();

    check("mis2_pulses", 32'(seen_mis2), 32'(model_mis2));
    check("err_cnt_final", 32'(err_cnt), 32'(model_err));
    check("err_cnt_w2_final", 32'(err2), 32'(model_err2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excite_drv.md
Name: jk_excite_drv

Overview:
- Driver for the other end of the JK flip-flop interface. The flip-flop consumes J/K; this block generates J/K excitation.
- It accepts target next-state words over a valid/ready handshake and derives per-bit J/K from the current state and the target.
- It pulses a clock-enable so the JK register bank loads once, then checks the bank's q feedback against the target.
- It sits between a pattern source (test sequencer or control FSM) and a W-bit bank of JK flip-flops sharing clk.

Parameters:
- W, 4, width of the JK register bank and of target words.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tgt_valid  in  1  target word valid.
- tgt_data  in  W  desired next state of the JK bank.
- tgt_ready  out  1  block can accept a target word.
- j  out  W  J excitation to the bank.
- k  out  W  K excitation to the bank.
- jk_en  out  1  one-cycle load enable to the bank.
- q_fb  in  W  q outputs of the JK bank.
- cur_state  out  W  tracked bank state (last checked q_fb).
- mismatch  out  1  one-cycle pulse when q_fb differs from the target.
- err_cnt  out  ERR_W  saturating count of mismatches.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; j=0; k=0; jk_en=0; cur_state=0; mismatch=0; err_cnt=0; tgt_ready=1; busy=0.
  - The bank is reset by the same rst_n to q=0, so cur_state=0 is consistent with it.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&&tgt_ready: register tgt_data into tgt_r, compute j/k, go to DRIVE.
  - Otherwise j=k=0 (hold).
- DRIVE (1 cycle):
  - jk_en=1; j/k hold the registered excitation; tgt_ready=0.
  - The bank loads at the end of this cycle. Next state: SETTLE.
- SETTLE (1 cycle):
  - jk_en=0; j=k=0. Allows the bank output to propagate.
  - Next state: CHECK.
- CHECK (1 cycle):
  - Compare q_fb with tgt_r.
  - Mismatch: mismatch=1 for this cycle; err_cnt increments, saturating at all-ones.
  - cur_state<=q_fb always, so the block resyncs to the real bank state.
  - Next state: IDLE.
- Throughput and latency:
  - One target per 4 cycles.
  - Accept at edge N; jk_en high in cycle N+1; mismatch is visible in cycle N+3; tgt_ready returns high in cycle N+4.
- Excitation, per bit i, with c=cur_state[i] and t=tgt_data[i]. Don't-cares are resolved to 0 (no toggle code is used):
  - 0->0: J=0, K=0
  - 0->1: J=1, K=0
  - 1->0: J=0, K=1
  - 1->1: J=0, K=0
- Invariants:
  - j&k is never nonzero in any bit.
  - jk_en is never high outside DRIVE.
- Boundary conditions:
  - tgt_valid high while busy: ignored and not consumed. The source must hold the word until the handshake completes.
  - Target equal to cur_state: still runs the full DRIVE/SETTLE/CHECK sequence with j=k=0 and still checks q_fb.
  - err_cnt at max: stays at max; mismatch still pulses.
  - rst_n asserted mid-operation: immediate return to IDLE with reset values. An in-flight target is discarded and not counted.
  - rst_n deassertion is synchronised by the system reset tree; the block requires no extra synchroniser.

Decomposition:
- Shared package jk_pkg:
  - FSM state enum (IDLE, DRIVE, SETTLE, CHECK), 2-bit encoding.
  - Excitation constants: JK_HOLD=2'b00, JK_SET=2'b10, JK_RST=2'b01.
- One natural sub-module: jk_excite_bit, a combinational per-bit (c,t)->(J,K) mapper, instantiated W times via generate.
- FSM, handshake, checker and counter stay in the top module.

Test Plan:
- Reset then targets 4'b1010, 4'b0101 into a real JK bank.
  - Expected: first word gives j=1010, k=0000 with jk_en in cycle N+1; second word gives j=0101, k=1010.
  - Expected: cur_state follows each target; mismatch never asserted; err_cnt=0.
- Target equal to current state (4'b0101 twice).
  - Expected: second pass has j=k=0000 with jk_en still pulsed; no mismatch; four cycles per word.
- Fault injection: force q_fb bit 0 stuck at 0, target 4'b0001.
  - Expected: mismatch pulses in CHECK; err_cnt=1; cur_state=0000.
  - Expected: next target 4'b0001 again drives j=0001, i.e. the block resynced to the real bank state.
- tgt_valid held high continuously with changing data.
  - Expected: only words present when tgt_ready=1 are consumed; no jk_en outside DRIVE.
- rst_n pulsed low during SETTLE.
  - Expected: outputs go to reset values asynchronously; err_cnt unchanged from 0; the next target is accepted normally.
- ERR_W=2 with 5 forced mismatches.
  - Expected: err_cnt reads 1,2,3,3,3; mismatch pulses 5 times.
